// File: rtl/nodf_module_status.sv
// Passive status tracker for one ap_start/ap_ready/ap_done/ap_continue HLS block.
// Optional macro STALL_COUNT_EN enables the stall_cycles counter (tied to 0 otherwise).
module nodf_module_status #(
    parameter int CNT_W = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       ap_start,
    input  logic                       ap_ready,
    input  logic                       ap_done,
    input  logic                       ap_continue,
    input  logic                       finish,
    output logic [1:0]                 status,
    output logic [CNT_W-1:0]           cycle,
    output logic [CNT_W-1:0]           start_cnt,
    output logic [CNT_W-1:0]           done_cnt,
    output logic [$clog2(DEPTH):0]     inflight,
    output logic [CNT_W-1:0]           last_lat,
    output logic [CNT_W-1:0]           max_lat,
    output logic [CNT_W-1:0]           stall_cycles,
    output logic                       evt_valid,
    output logic [1:0]                 evt_type,
    output logic [CNT_W-1:0]           evt_time,
    output logic                       err_ovf,
    output logic                       err_unf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int INF_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACTIVE   = 2'd1,
        ST_STALL    = 2'd2,
        ST_FINISHED = 2'd3
    } status_e;

    localparam logic [1:0] EVT_START = 2'd0;
    localparam logic [1:0] EVT_DONE  = 2'd1;
    localparam logic [1:0] EVT_BOTH  = 2'd2;
    localparam logic [1:0] EVT_ERROR = 2'd3;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    logic [CNT_W-1:0] cycle_q, start_cnt_q, done_cnt_q, last_lat_q, max_lat_q, evt_time_q;
    logic [INF_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic             finished_q, evt_valid_q, err_ovf_q, err_unf_q;
    logic [1:0]       evt_type_q;

    logic [DEPTH-1:0][CNT_W-1:0] ts_all;
    logic [CNT_W-1:0] head_ts, lat_val;
    logic             s_acc, d_acc, fifo_empty, fifo_full;
    logic             push, pop, start_inc, done_inc, lat_upd, evt_fire, set_ovf, set_unf;
    logic [1:0]       evt_kind;
    status_e          st_now;

    assign s_acc      = ap_start & ap_ready;
    assign d_acc      = ap_done & ap_continue;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == INF_W'(DEPTH));
    assign head_ts    = ts_all[rd_ptr_q];

    // Start-timestamp storage: one register per slot, written at the write pointer.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ts
            logic [CNT_W-1:0] ts_q;
            always_ff @(posedge clock) begin
                if (reset) begin
                    ts_q <= '0;
                end else if (push && (wr_ptr_q == PTR_W'(gi))) begin
                    ts_q <= cycle_q;
                end
            end
            assign ts_all[gi] = ts_q;
        end
    endgenerate

    // Handshake decode; a simultaneous done pops before the start pushes.
    always_comb begin
        push      = 1'b0;
        pop       = 1'b0;
        start_inc = 1'b0;
        done_inc  = 1'b0;
        lat_upd   = 1'b0;
        lat_val   = '0;
        evt_fire  = 1'b0;
        evt_kind  = EVT_START;
        set_ovf   = 1'b0;
        set_unf   = 1'b0;
        if (!finished_q) begin
            if (s_acc && d_acc) begin
                start_inc = 1'b1;
                done_inc  = 1'b1;
                lat_upd   = 1'b1;
                evt_fire  = 1'b1;
                evt_kind  = EVT_BOTH;
                if (!fifo_empty) begin
                    push    = 1'b1;
                    pop     = 1'b1;
                    lat_val = cycle_q - head_ts;
                end
            end else if (s_acc) begin
                evt_fire = 1'b1;
                if (fifo_full) begin
                    set_ovf  = 1'b1;
                    evt_kind = EVT_ERROR;
                end else begin
                    push      = 1'b1;
                    start_inc = 1'b1;
                    evt_kind  = EVT_START;
                end
            end else if (d_acc) begin
                evt_fire = 1'b1;
                if (fifo_empty) begin
                    set_unf  = 1'b1;
                    evt_kind = EVT_ERROR;
                end else begin
                    pop      = 1'b1;
                    done_inc = 1'b1;
                    lat_upd  = 1'b1;
                    lat_val  = cycle_q - head_ts;
                    evt_kind = EVT_DONE;
                end
            end
        end
    end

    always_comb begin
        case ({push, pop})
            2'b10:   count_d = count_q + INF_W'(1);
            2'b01:   count_d = count_q - INF_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        st_now = ST_IDLE;
        if (finished_q) begin
            st_now = ST_FINISHED;
        end else if (ap_done && !ap_continue) begin
            st_now = ST_STALL;
        end else if (!fifo_empty || ap_start) begin
            st_now = ST_ACTIVE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_q     <= '0;
            start_cnt_q <= '0;
            done_cnt_q  <= '0;
            last_lat_q  <= '0;
            max_lat_q   <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            finished_q  <= 1'b0;
            evt_valid_q <= 1'b0;
            evt_type_q  <= EVT_START;
            evt_time_q  <= '0;
            err_ovf_q   <= 1'b0;
            err_unf_q   <= 1'b0;
        end else if (!finished_q) begin
            cycle_q     <= cycle_q + CNT_W'(1);
            finished_q  <= finish;
            count_q     <= count_d;
            evt_valid_q <= evt_fire;
            if (start_inc) start_cnt_q <= sat_inc(start_cnt_q);
            if (done_inc)  done_cnt_q  <= sat_inc(done_cnt_q);
            if (push)      wr_ptr_q    <= wr_ptr_q + PTR_W'(1);
            if (pop)       rd_ptr_q    <= rd_ptr_q + PTR_W'(1);
            if (set_ovf)   err_ovf_q   <= 1'b1;
            if (set_unf)   err_unf_q   <= 1'b1;
            if (lat_upd) begin
                last_lat_q <= lat_val;
                if (lat_val > max_lat_q) max_lat_q <= lat_val;
            end
            if (evt_fire) begin
                evt_type_q <= evt_kind;
                evt_time_q <= cycle_q;
            end
        end else begin
            evt_valid_q <= 1'b0;
        end
    end

`ifdef STALL_COUNT_EN
    logic [CNT_W-1:0] stall_q;
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_q <= '0;
        end else if (st_now == ST_STALL) begin
            stall_q <= sat_inc(stall_q);
        end
    end
    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

    assign status    = st_now;
    assign cycle     = cycle_q;
    assign start_cnt = start_cnt_q;
    assign done_cnt  = done_cnt_q;
    assign inflight  = count_q;
    assign last_lat  = last_lat_q;
    assign max_lat   = max_lat_q;
    assign evt_valid = evt_valid_q;
    assign evt_type  = evt_type_q;
    assign evt_time  = evt_time_q;
    assign err_ovf   = err_ovf_q;
    assign err_unf   = err_unf_q;

endmodule

// File: tb/tb_nodf_module_status.sv
// Bench for nodf_module_status: directed vector table plus randomized run against a queue-based model.
module tb_nodf_module_status;

    localparam int DEPTH = 4;

    logic        clock, reset, ap_start, ap_ready, ap_done, ap_continue, finish;
    logic [1:0]  status, evt_type;
    logic [31:0] cycle, start_cnt, done_cnt, last_lat, max_lat, stall_cycles, evt_time;
    logic [2:0]  inflight;
    logic        evt_valid, err_ovf, err_unf;

    int total = 0;
    int bad   = 0;

    nodf_module_status #(.CNT_W(32), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done),
        .ap_continue(ap_continue), .finish(finish),
        .status(status), .cycle(cycle), .start_cnt(start_cnt), .done_cnt(done_cnt),
        .inflight(inflight), .last_lat(last_lat), .max_lat(max_lat),
        .stall_cycles(stall_cycles), .evt_valid(evt_valid), .evt_type(evt_type),
        .evt_time(evt_time), .err_ovf(err_ovf), .err_unf(err_unf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: start timestamps in a queue, everything else plain counters.
    logic [31:0] m_q[$];
    logic [31:0] m_cycle, m_start, m_done, m_last, m_max, m_stall, m_evt_time;
    bit          m_fin, m_ovf, m_unf, m_evt_v;
    int          m_evt_t;

    function automatic logic [31:0] sinc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic int model_status(input bit s, input bit d, input bit c);
        if (m_fin) return 3;
        if (d && !c) return 2;
        if (m_q.size() > 0 || s) return 1;
        return 0;
    endfunction

    task automatic retire(input logic [31:0] lat);
        m_done = sinc(m_done);
        m_last = lat;
        if (lat > m_max) m_max = lat;
    endtask

    task automatic model_step(input bit rst, input bit s, input bit r, input bit d,
                              input bit c, input bit f);
        bit sa, da;
        logic [31:0] head;
        if (rst) begin
            m_q.delete();
            m_cycle = 0; m_start = 0; m_done = 0; m_last = 0; m_max = 0; m_stall = 0;
            m_evt_time = 0; m_fin = 0; m_ovf = 0; m_unf = 0; m_evt_v = 0; m_evt_t = 0;
            return;
        end
        if (m_fin) begin
            m_evt_v = 0;
            return;
        end
        sa = s & r;
        da = d & c;
        m_evt_v = sa | da;
        m_evt_time = m_cycle;
        if (sa && da) begin
            m_evt_t = 2;
            m_start = sinc(m_start);
            if (m_q.size() == 0) begin
                retire(32'd0);
            end else begin
                head = m_q.pop_front();
                retire(m_cycle - head);
                m_q.push_back(m_cycle);
            end
        end else if (sa) begin
            if (m_q.size() == DEPTH) begin
                m_ovf = 1; m_evt_t = 3;
            end else begin
                m_q.push_back(m_cycle); m_start = sinc(m_start); m_evt_t = 0;
            end
        end else if (da) begin
            if (m_q.size() == 0) begin
                m_unf = 1; m_evt_t = 3;
            end else begin
                head = m_q.pop_front();
                retire(m_cycle - head);
                m_evt_t = 1;
            end
        end
`ifdef STALL_COUNT_EN
        if (d && !c) m_stall = sinc(m_stall);
`endif
        m_cycle = m_cycle + 32'd1;
        if (f) m_fin = 1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_model();
        chk("m_cycle", cycle, m_cycle);
        chk("m_start_cnt", start_cnt, m_start);
        chk("m_done_cnt", done_cnt, m_done);
        chk("m_inflight", 32'(inflight), 32'(m_q.size()));
        chk("m_last_lat", last_lat, m_last);
        chk("m_max_lat", max_lat, m_max);
        chk("m_stall_cycles", stall_cycles, m_stall);
        chk("m_evt_valid", 32'(evt_valid), 32'(m_evt_v));
        if (m_evt_v) begin
            chk("m_evt_type", 32'(evt_type), 32'(m_evt_t));
            chk("m_evt_time", evt_time, m_evt_time);
        end
        chk("m_err_ovf", 32'(err_ovf), 32'(m_ovf));
        chk("m_err_unf", 32'(err_unf), 32'(m_unf));
    endtask

    // Drive one cycle: check combinational status, advance model, clock, check registers.
    task automatic apply(input bit rst, input bit s, input bit r, input bit d,
                         input bit c, input bit f);
        reset = rst; ap_start = s; ap_ready = r; ap_done = d; ap_continue = c; finish = f;
        #1;
        if (!rst) chk("m_status", 32'(status), 32'(model_status(s, d, c)));
        model_step(rst, s, r, d, c, f);
        @(posedge clock);
        #1;
        chk_model();
    endtask

    typedef struct {
        bit rst, st, rd, dn, ct, fin;
        int e_status;
        int e_cycle, e_start, e_done, e_infl;
        bit e_evv;
        int e_evt, e_lat;
    } vec_t;

    vec_t tbl[$];

    function automatic void v(input bit rst, input bit st, input bit rd, input bit dn,
                              input bit ct, input bit fin, input int es, input int ecy,
                              input int esc, input int edc, input int ein, input bit eev,
                              input int eet, input int elat);
        vec_t x;
        x.rst = rst; x.st = st; x.rd = rd; x.dn = dn; x.ct = ct; x.fin = fin;
        x.e_status = es; x.e_cycle = ecy; x.e_start = esc; x.e_done = edc;
        x.e_infl = ein; x.e_evv = eev; x.e_evt = eet; x.e_lat = elat;
        tbl.push_back(x);
    endfunction

    initial begin
        reset = 1'b1; ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 0; finish = 0;
        model_step(1, 0, 0, 0, 0, 0);

        // Expected values below are the post-edge register values for the cycle whose
        // pre-edge cycle count is c; e_status is the combinational status before the edge.
        for (int i = 0; i < 3; i++) v(1, 0, 0, 0, 0, 0, -1, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 10; c++) v(0, 0, 0, 0, 0, 0, 0, c + 1, 0, 0, 0, 0, 0, 0);
        v(0, 1, 1, 0, 0, 0, 1, 11, 1, 0, 1, 1, 0, 0);
        for (int c = 11; c < 17; c++) v(0, 0, 0, 0, 0, 0, 1, c + 1, 1, 0, 1, 0, 0, 0);
        v(0, 0, 0, 1, 1, 0, 1, 18, 1, 1, 0, 1, 1, 7);
        v(0, 0, 0, 0, 0, 0, 0, 19, 1, 1, 0, 0, 0, 7);
        for (int c = 19; c < 23; c++) v(0, 1, 1, 0, 0, 0, 1, c + 1, c - 17, 1, c - 18, 1, 0, 7);
        v(0, 1, 1, 0, 0, 0, 1, 24, 5, 1, 4, 1, 3, 7);
        v(0, 0, 0, 0, 0, 0, 1, 25, 5, 1, 4, 0, 0, 7);
        for (int c = 25; c < 31; c++) v(0, 0, 0, 1, 0, 0, 2, c + 1, 5, 1, 4, 0, 0, 7);
        for (int c = 31; c < 35; c++) v(0, 0, 0, 1, 1, 0, 1, c + 1, 5, c - 29, 34 - c, 1, 1, 12);
        v(0, 0, 0, 1, 1, 0, 0, 36, 5, 5, 0, 1, 3, 12);
        v(0, 1, 1, 1, 1, 0, 1, 37, 6, 6, 0, 1, 2, 0);
        for (int c = 37; c < 40; c++) v(0, 0, 0, 0, 0, 0, 0, c + 1, 6, 6, 0, 0, 0, 0);
        v(0, 1, 1, 0, 0, 1, 1, 41, 7, 6, 1, 1, 0, 0);
        v(0, 1, 1, 1, 1, 0, 3, 41, 7, 6, 1, 0, 0, 0);
        v(0, 1, 1, 0, 0, 1, 3, 41, 7, 6, 1, 0, 0, 0);
        v(0, 0, 0, 1, 0, 0, 3, 41, 7, 6, 1, 0, 0, 0);
        v(1, 0, 0, 0, 0, 0, -1, 0, 0, 0, 0, 0, 0, 0);
        v(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

        @(posedge clock);
        #1;
        foreach (tbl[i]) begin
            reset = tbl[i].rst; ap_start = tbl[i].st; ap_ready = tbl[i].rd;
            ap_done = tbl[i].dn; ap_continue = tbl[i].ct; finish = tbl[i].fin;
            #1;
            if (tbl[i].e_status >= 0) chk("tbl_status", 32'(status), 32'(tbl[i].e_status));
            apply(tbl[i].rst, tbl[i].st, tbl[i].rd, tbl[i].dn, tbl[i].ct, tbl[i].fin);
            chk("tbl_cycle", cycle, 32'(tbl[i].e_cycle));
            chk("tbl_start_cnt", start_cnt, 32'(tbl[i].e_start));
            chk("tbl_done_cnt", done_cnt, 32'(tbl[i].e_done));
            chk("tbl_inflight", 32'(inflight), 32'(tbl[i].e_infl));
            chk("tbl_evt_valid", 32'(evt_valid), 32'(tbl[i].e_evv));
            if (tbl[i].e_evv) chk("tbl_evt_type", 32'(evt_type), 32'(tbl[i].e_evt));
            chk("tbl_last_lat", last_lat, 32'(tbl[i].e_lat));
            $display("vec %0d: cyc=%0d st=%0d starts=%0d dones=%0d infl=%0d evt=%0b/%0d",
                     i, cycle, status, start_cnt, done_cnt, inflight, evt_valid, evt_type);
        end

        // Hand-written corner checks on sticky flags and the stall counter.
        apply(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) apply(0, 1, 1, 0, 0, 0);
        chk("ovf_sticky", 32'(err_ovf), 32'd1);
        chk("ovf_start_cnt", start_cnt, 32'd4);
        for (int i = 0; i < 6; i++) apply(0, 0, 0, 1, 0, 0);
`ifdef STALL_COUNT_EN
        chk("stall_six", stall_cycles, 32'd6);
`else
        chk("stall_tied", stall_cycles, 32'd0);
`endif
        apply(1, 0, 0, 0, 0, 0);
        apply(0, 0, 0, 1, 1, 0);
        chk("unf_sticky", 32'(err_unf), 32'd1);
        chk("unf_done_cnt", done_cnt, 32'd0);

        // Randomized run against the model.
        apply(1, 0, 0, 0, 0, 0);
        for (int n = 0; n < 600; n++) begin
            bit rr, ss, rd, dd, cc, ff;
            rr = ($urandom_range(0, 79) == 0);
            ss = ($urandom_range(0, 99) < 55);
            rd = ($urandom_range(0, 99) < 70);
            dd = ($urandom_range(0, 99) < 50);
            cc = ($urandom_range(0, 99) < 60);
            ff = ($urandom_range(0, 249) == 0);
            apply(rr, ss, rd, dd, cc, ff);
            if (evt_valid)
                $display("rnd %0d: event type=%0d time=%0d starts=%0d dones=%0d lat=%0d",
                         n, evt_type, evt_time, start_cnt, done_cnt, last_lat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nodf_module_status.md
Name: nodf_module_status

Overview:
- Cycle-accurate status tracker for one non-dataflow HLS module driven by the ap_start/ap_ready/ap_done/ap_continue block-level handshake.
- Counts accepted starts and completions and measures per-transaction latency using a FIFO of start timestamps.
- Reports the module state and emits one event strobe per handshake, so a trace dumper can record status rows.
- Sits beside the module under observation; it is passive and never drives the handshake.

Parameters:
- CNT_W, 32, width of the cycle timestamp and of all counters.
- DEPTH, 4, maximum in-flight transactions tracked (start-timestamp FIFO depth, power of 2, ≥2).

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- ap_start  input  1  observed start request.
- ap_ready  input  1  observed ready; start accepted when ap_start&&ap_ready.
- ap_done  input  1  observed done.
- ap_continue  input  1  observed continue; done accepted when ap_done&&ap_continue.
- finish  input  1  end of simulation/run; freezes tracking.
- status  output  2  0=IDLE, 1=ACTIVE, 2=STALL, 3=FINISHED.
- cycle  output  CNT_W  cycle count since reset deassertion.
- start_cnt  output  CNT_W  accepted starts.
- done_cnt  output  CNT_W  accepted dones.
- inflight  output  $clog2(DEPTH)+1  started but not yet done.
- last_lat  output  CNT_W  latency of the most recent completion (done cycle − start cycle).
- max_lat  output  CNT_W  maximum latency observed.
- stall_cycles  output  CNT_W  cycles spent in STALL.
- evt_valid  output  1  one-cycle event strobe.
- evt_type  output  2  0=START, 1=DONE, 2=START+DONE in the same cycle, 3=ERROR.
- evt_time  output  CNT_W  cycle value of the event.
- err_ovf  output  1  sticky; a start was accepted while the FIFO was full.
- err_unf  output  1  sticky; a done was accepted with nothing in flight.

Behaviour:
- Reset (synchronous, high): all outputs and counters go to 0 and status goes to IDLE. The FIFO is emptied. This applies mid-transaction too; pending starts are discarded.
- cycle increments every clock while not FINISHED. It wraps modulo 2^CNT_W. Latency subtraction is modulo 2^CNT_W, so a wrap yields the correct difference.
- Start accept (S = ap_start&ap_ready): push the current cycle value into the FIFO, increment start_cnt, increment inflight.
- If the FIFO is full on S: do not push or count, set err_ovf, emit an ERROR event.
- Done accept (D = ap_done&ap_continue), FIFO non-empty: pop the head, set last_lat = cycle − head, update max_lat when last_lat exceeds it, increment done_cnt, decrement inflight.
- Done accept with the FIFO empty: set err_unf and emit ERROR; counters are unchanged.
- Same-cycle S and D with the FIFO empty: latency is 0. The start is counted and immediately retired, inflight is unchanged, and the event is type 2.
- Same-cycle S and D with the FIFO full: the pop happens first, so the push succeeds and there is no overflow.
- Event outputs are registered, so evt_valid appears the cycle after the accept. evt_time carries the accept cycle. ERROR takes priority over other event types.
- status, computed combinationally from registered state and current inputs:
  - FINISHED once finish has been sampled high; sticky until reset.
  - Else STALL if ap_done=1 and ap_continue=0.
  - Else ACTIVE if inflight>0 or ap_start=1.
  - Else IDLE.
- FINISHED: all counters, the FIFO and cycle freeze; evt_valid is held 0; inputs are ignored. An accept in the same cycle finish rises is still processed.
- Counters saturate at the all-ones value; there is no wrap except for cycle.

Optional Feature:
- Macro STALL_COUNT_EN.
- Defined: stall_cycles increments once per clock while status==STALL (saturating) and freezes in FINISHED.
- Undefined: stall_cycles is tied to 0 and no counter logic is generated.

Test Plan:
- Reset held 3 cycles, then released with all inputs 0 → status=0, counters 0, cycle reaches 5 five cycles after release.
- Start accepted at cycle 10 and done accepted at cycle 17 → start_cnt=1, done_cnt=1, last_lat=7, max_lat=7, two events at cycles 10 and 17 (types 0, 1), inflight back to 0.
- DEPTH=4: five back-to-back accepted starts without done → start_cnt=4, err_ovf=1, fifth event type 3, inflight=4, status=1.
- ap_done=1 with ap_continue=0 for 6 cycles, then continue=1 → status=2 for 6 cycles, stall_cycles=6 with STALL_COUNT_EN (0 without), then done accepted.
- Done accepted with nothing in flight → err_unf=1, event type 3, done_cnt stays 0. Then start and done in the same cycle → event type 2, last_lat=0.
- finish asserted at cycle 40 followed by further handshakes → status=3, cycle stays at 41, counters unchanged. A subsequent reset returns all outputs to 0.
